// File: rtl/kernel_bank_loader.sv
// Purpose: fetches a full kernel set into a shadow bank and commits it to the PE-facing active bank.
// Latency: load_done E+RD_LATENCY+1 cycles after load_start; commit one cycle after READY sees permission.
// Backpressure: load_start is ignored while a load is busy or pending; commits wait for swap_req once a set is active.
module kernel_bank_loader #(
    parameter int KERNEL_SIZE       = 3,
    parameter int KERNEL_DATA_WIDTH = 8,
    parameter int CHANNELS          = 3,
    parameter int NUM_KERNELS       = 3,
    parameter int RD_LATENCY        = 1,
    localparam int E  = KERNEL_SIZE * KERNEL_SIZE * CHANNELS,
    localparam int KW = E * KERNEL_DATA_WIDTH,
    localparam int AW = (E > 1) ? $clog2(E) : 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      load_start,
    input  logic                                      swap_req,
    output logic                                      mem_en,
    output logic [AW-1:0]                             mem_addr,
    input  logic [NUM_KERNELS*KERNEL_DATA_WIDTH-1:0]  mem_rdata,
    output logic [NUM_KERNELS*KW-1:0]                 kernels_out,
    output logic                                      kernels_valid,
    output logic                                      load_busy,
    output logic                                      shadow_full,
    output logic                                      load_done,
    output logic                                      commit_pulse
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

    state_t                    state;
    logic [AW-1:0]             issue_cnt;
    logic [AW-1:0]             cap_cnt;
    logic [RD_LATENCY-1:0]     vld_pipe;
    logic [NUM_KERNELS*KW-1:0] shadow;
    logic                      cap_vld;

    // Read data is valid exactly RD_LATENCY cycles after an issued address.
    assign cap_vld = vld_pipe[RD_LATENCY-1];

    // Valid pipeline follows mem_en; cleared on reset so in-flight reads are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | RD_LATENCY'(mem_en);
        end
    end

    // Load/commit FSM; every output is a register written here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            issue_cnt     <= '0;
            cap_cnt       <= '0;
            mem_en        <= 1'b0;
            mem_addr      <= '0;
            kernels_out   <= '0;
            kernels_valid <= 1'b0;
            load_busy     <= 1'b0;
            shadow_full   <= 1'b0;
            load_done     <= 1'b0;
            commit_pulse  <= 1'b0;
        end else begin
            load_done    <= 1'b0;
            commit_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state     <= FETCH;
                        load_busy <= 1'b1;
                        issue_cnt <= '0;
                        cap_cnt   <= '0;
                    end
                end
                FETCH: begin
                    mem_en    <= 1'b1;
                    mem_addr  <= issue_cnt;
                    issue_cnt <= issue_cnt + 1'b1;
                    if (issue_cnt == AW'(E - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    mem_en <= 1'b0;
                end
                READY: begin
                    // An empty active bank is filled without waiting for a tile boundary.
                    if (swap_req || !kernels_valid) begin
                        kernels_out   <= shadow;
                        kernels_valid <= 1'b1;
                        commit_pulse  <= 1'b1;
                        shadow_full   <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Last returning word completes the shadow bank.
            if (cap_vld) begin
                cap_cnt <= cap_cnt + 1'b1;
                if (cap_cnt == AW'(E - 1)) begin
                    state       <= READY;
                    load_busy   <= 1'b0;
                    shadow_full <= 1'b1;
                    load_done   <= 1'b1;
                end
            end
        end
    end

    // Shadow capture: address 0 lands in the MSBs of each kernel slice.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (cap_vld) begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                shadow[k*KW + (E - 1 - int'(cap_cnt))*KERNEL_DATA_WIDTH +: KERNEL_DATA_WIDTH]
                    <= mem_rdata[k*KERNEL_DATA_WIDTH +: KERNEL_DATA_WIDTH];
            end
        end
    end

endmodule
